dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Sequences and shares the word-wide, 1-cycle-read-latency data RAM (dmem) between two requesters:
//  the pipeline MEM stage (port P) and the program/data loader (port L).
//  Performs RV32 byte/half/word loads with sign/zero extension.
//  Sub-word stores are done as read-modify-write. Misaligned or out-of-range accesses are flagged.
// PARAMETERS
//  ADDR_WIDTH  9   word-address width of dmem; byte address space = 2**(ADDR_WIDTH+2)
//  DATA_WIDTH  32  RAM word width; fixed at 32, elaborate-time error otherwise
// PORTS
//  i_clk        in   1           clock, all state on posedge
//  i_rst_n      in   1           async active-low reset
//  i_p_req      in   1           port P request; hold req and fields stable until o_p_done
//  i_p_we       in   1           1 = store, 0 = load
//  i_p_funct3   in   3           RV32 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_p_addr     in   32          byte address
//  i_p_wdata    in   32          store data, right-aligned
//  o_p_done     out  1           one-cycle completion pulse
//  o_p_err      out  1           valid with o_p_done: access rejected, RAM untouched
//  o_p_rdata    out  32          load result, extended; valid with o_p_done
//  i_l_*/o_l_*  -    as above    port L, identical set
//  o_ram_we     out  1           dmem write enable (registered)
//  o_ram_addr   out  ADDR_WIDTH  dmem word address (registered)
//  o_ram_wdata  out  32          dmem write word (registered)
//  i_ram_rdata  in   32          dmem read word, valid 1 edge after o_ram_addr
//  o_busy       out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, last_grant=L, so P wins first contention.
//  States: IDLE, RD, WAIT, WR, DONE. E0 = accepting edge in IDLE.
//  Arbitration in IDLE: only one req -> grant it.
//   Both reqs -> grant the port not in last_grant. Update last_grant on grant.
//  Error check at E0: funct3 not in the legal set; store with funct3 100/101; H with addr[0]!=0;
//   W with addr[1:0]!=0; addr[31:ADDR_WIDTH+2]!=0.
//   On error: -> DONE with err=1, rdata=0, no RAM access.
//  Load: E0 reg addr, we=0, ->RD. E1 RAM read, ->WAIT. E2 extract lane per addr[1:0],
//   extend, reg rdata, done=1, ->DONE.
//  SW: E0 reg addr, wdata, we=1, ->WR. E1 RAM write, we->0, done=1, ->DONE.
//  SB/SH: E0 read as load. E2 merge the new lane into i_ram_rdata, reg wdata, we=1, ->WR.
//   E3 RAM write, done=1, ->DONE.
//  DONE lasts exactly 1 cycle; done/err high; requests ignored; then ->IDLE.
//   The requester may drop req at the edge ending DONE.
//  Lane mapping (little-endian): byte k = bits [8k+7:8k]; half at addr[1]=1 = bits [31:16].
//  o_ram_we is never high for more than 1 cycle per access.
//  Only the granted port's done/err/rdata are driven; the other port's outputs stay 0.
//  Async reset mid-access: immediately IDLE, we=0, done=0.
//   An RMW not yet at its write edge leaves the RAM word unchanged.
//  Req dropped before done: protocol violation. The controller completes the access regardless.
// STRUCTURE
//  Package dmem_pkg: size enum (funct3 codes), state enum, port index constants P=0/L=1,
//   localparam BADDR_WIDTH.
//  Sub-module dmem_lane_align (combinational): extract+extend for loads, merge for sub-word stores.
//  Top: FSM, arbiter, request mux, registered RAM-side outputs.
// TESTING
//  1. P: SW 0xDEADBEEF @0x10 -> done 1 cycle after E1, RAM[4]=DEADBEEF.
//     Then LW @0x10 -> rdata DEADBEEF at E2.
//  2. RAM[4]=0x11223344; P: SB 0xAA @0x11 -> RAM[4]=0x1122AA44, done after E3.
//     LB @0x11 -> 0xFFFFFFAA; LBU -> 0x000000AA.
//  3. P: LH @0x13 and SW @0x800 -> done+err, rdata 0, o_ram_we never asserted.
//  4. P and L req together out of reset, held: grant order P,L,P,L.
//     Each done is exclusive to its own port.
//  5. SH 0xBEEF @0x12 over 0x11223344; assert i_rst_n=0 in WAIT -> o_ram_we=0, o_busy=0.
//     RAM[4] remains 0x11223344.
//  6. L: store with funct3 011, then LBU with we=1 -> err on both.
//     Next legal P load completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_pkg
// Description : Shared types and helpers for the data-memory controller:
//               RV32 load/store size codes, controller state encoding,
//               requester port indices and access legality checks.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Default byte-address width: 9-bit word address -> 2 KiB of dmem.
    localparam int unsigned BADDR_WIDTH = 11;

    // Requester indices; also the encoding of the last-grant flop.
    localparam logic c_PORT_P = 1'b0;
    localparam logic c_PORT_L = 1'b1;

    // Access size as carried in funct3[1:0].
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Unknown size codes are always rejected; the unsigned variants only
    // make sense for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic r;
        case (f3)
            F3_B, F3_H, F3_W: r = 1'b0;
            F3_BU, F3_HU:     r = we;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic r;
        case (f3[1:0])
            c_SZ_HALF: r = lane[0];
            c_SZ_WORD: r = |lane;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : dmem_ctrl_if
// Description : One requester's load/store channel into the dmem controller.
//               master : requester side (drives req/we/funct3/addr/wdata)
//               slave  : controller side (drives done/err/rdata)
//               req and all request fields are held stable until done.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  done, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output done, err, rdata
    );
endinterface : dmem_ctrl_if
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering for the dmem controller.
//               Loads : pick byte/half/word from the RAM word by lane and
//                       sign- or zero-extend it.
//               Stores: merge a byte/half into the old RAM word (RMW).
// Ports       : i_funct3     RV32 size code of the access
//               i_lane       byte address bits [1:0]
//               i_ram_word   word read from dmem
//               i_store_data right-aligned store data (low half is enough)
//               o_load_data  extended load result
//               o_merged     RAM word with the new lane inserted
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire  [2:0]  i_funct3,
    input  wire  [1:0]  i_lane,
    input  wire  [31:0] i_ram_word,
    input  wire  [15:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;
    logic        w_is_half;

    assign w_byte    = i_ram_word[{i_lane, 3'b000} +: 8];
    assign w_half    = i_lane[1] ? i_ram_word[31:16] : i_ram_word[15:0];
    // funct3[2] marks the unsigned (BU/HU) variants.
    assign w_signed  = ~i_funct3[2];
    assign w_is_half = (i_funct3[1:0] == c_SZ_HALF);

    always_comb begin
        o_load_data = i_ram_word;
        case (i_funct3[1:0])
            c_SZ_BYTE: o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: o_load_data = {{16{w_signed & w_half[15]}}, w_half};
            default:   o_load_data = i_ram_word;
        endcase
    end

    // Each byte lane either keeps the old RAM byte or takes the new data.
    // A half store covers lanes {0,1} or {2,3} selected by lane[1].
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
        localparam logic [1:0] c_LANE = 2'(gi);
        logic       w_hit;
        logic [7:0] w_new;

        assign w_hit = w_is_half ? (i_lane[1] == c_LANE[1]) : (i_lane == c_LANE);
        assign w_new = w_is_half ? i_store_data[8*(gi%2) +: 8] : i_store_data[7:0];
        assign o_merged[8*gi +: 8] = w_hit ? w_new : i_ram_word[8*gi +: 8];
    end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Shares a 1-cycle-read-latency word RAM between the pipeline
//               MEM stage (port P) and the loader (port L). Round-robin
//               arbitration, RV32 B/H/W loads with extension, sub-word
//               stores as read-modify-write, error flagging for illegal,
//               misaligned or out-of-range accesses.
// Ports       : i_clk, i_rst_n     clock, async active-low reset
//               p_if, l_if         requester channels (slave side)
//               o_ram_we/addr/wdata registered dmem controls
//               i_ram_rdata        dmem read word, 1 edge after o_ram_addr
//               o_busy             controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BADDR_WIDTH - 2,
    parameter int unsigned DATA_WIDTH = 32
)(
    input  wire                   i_clk,
    input  wire                   i_rst_n,
    dmem_ctrl_if.slave            p_if,
    dmem_ctrl_if.slave            l_if,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  wire  [DATA_WIDTH-1:0] i_ram_rdata,
    output logic                  o_busy
);

    localparam int unsigned c_BADDR_W = ADDR_WIDTH + 2;

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("dmem_ctrl: DATA_WIDTH must be 32");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q,      state_d;
    logic                    last_grant_q, last_grant_d;  // also the current owner
    logic                    op_we_q,      op_we_d;
    logic [2:0]              op_f3_q,      op_f3_d;
    logic [1:0]              op_lane_q,    op_lane_d;
    logic [15:0]             op_wdata_q,   op_wdata_d;
    logic                    ram_we_q,     ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q,   ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q,  ram_wdata_d;
    logic [1:0]              done_q,       done_d;
    logic [1:0]              err_q,        err_d;
    logic [1:0][31:0]        rdata_q,      rdata_d;

    // ------------------------------------------------------------------
    // Arbitration and request mux
    // ------------------------------------------------------------------
    logic        w_any_req;
    logic        w_grant;
    logic        w_sel_we;
    logic [2:0]  w_sel_f3;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_err;

    assign w_any_req = p_if.req | l_if.req;
    // On contention the port that did not win last time goes next.
    assign w_grant   = (p_if.req & l_if.req) ? ~last_grant_q
                     : (p_if.req ? c_PORT_P : c_PORT_L);

    assign w_sel_we    = (w_grant == c_PORT_L) ? l_if.we     : p_if.we;
    assign w_sel_f3    = (w_grant == c_PORT_L) ? l_if.funct3 : p_if.funct3;
    assign w_sel_addr  = (w_grant == c_PORT_L) ? l_if.addr   : p_if.addr;
    assign w_sel_wdata = (w_grant == c_PORT_L) ? l_if.wdata  : p_if.wdata;

    assign w_err = f3_illegal(w_sel_we, w_sel_f3)
                 | misaligned(w_sel_f3, w_sel_addr[1:0])
                 | (|w_sel_addr[31:c_BADDR_W]);

    // ------------------------------------------------------------------
    // Lane steering on the word coming back from RAM
    // ------------------------------------------------------------------
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    dmem_lane_align u_lane_align (
        .i_funct3     (op_f3_q),
        .i_lane       (op_lane_q),
        .i_ram_word   (i_ram_rdata),
        .i_store_data (op_wdata_q),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_we_d      = op_we_q;
        op_f3_d      = op_f3_q;
        op_lane_d    = op_lane_q;
        op_wdata_d   = op_wdata_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    last_grant_d = w_grant;
                    op_we_d      = w_sel_we;
                    op_f3_d      = w_sel_f3;
                    op_lane_d    = w_sel_addr[1:0];
                    op_wdata_d   = w_sel_wdata[15:0];
                    if (w_err) begin
                        // Rejected: report at once, RAM is never touched.
                        done_d[w_grant]  = 1'b1;
                        err_d[w_grant]   = 1'b1;
                        rdata_d[w_grant] = '0;
                        state_d          = ST_DONE;
                    end else begin
                        ram_addr_d = w_sel_addr[c_BADDR_W-1:2];
                        if (w_sel_we && (w_sel_f3[1:0] == c_SZ_WORD)) begin
                            // Full word store needs no read.
                            ram_wdata_d = w_sel_wdata;
                            ram_we_d    = 1'b1;
                            state_d     = ST_WR;
                        end else begin
                            // Loads and sub-word stores start with a read.
                            ram_we_d = 1'b0;
                            state_d  = ST_RD;
                        end
                    end
                end
            end

            ST_RD: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (op_we_q) begin
                    ram_wdata_d = w_merged;
                    ram_we_d    = 1'b1;
                    state_d     = ST_WR;
                end else begin
                    rdata_d[last_grant_q] = w_load_data;
                    done_d[last_grant_q]  = 1'b1;
                    state_d               = ST_DONE;
                end
            end

            ST_WR: begin
                ram_we_d             = 1'b0;
                done_d[last_grant_q] = 1'b1;
                state_d              = ST_DONE;
            end

            ST_DONE: begin
                // Requests are ignored here; the requester may drop req now.
                done_d  = '0;
                err_d   = '0;
                rdata_d = '0;
                state_d = ST_IDLE;
            end

            default: begin
                ram_we_d = 1'b0;
                done_d   = '0;
                err_d    = '0;
                rdata_d  = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= c_PORT_L;   // P wins the first contention
            op_we_q      <= 1'b0;
            op_f3_q      <= '0;
            op_lane_q    <= '0;
            op_wdata_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_we_q      <= op_we_d;
            op_f3_q      <= op_f3_d;
            op_lane_q    <= op_lane_d;
            op_wdata_q   <= op_wdata_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;
    assign o_busy      = (state_q != ST_IDLE);

    assign p_if.done  = done_q[c_PORT_P];
    assign p_if.err   = err_q[c_PORT_P];
    assign p_if.rdata = rdata_q[c_PORT_P];
    assign l_if.done  = done_q[c_PORT_L];
    assign l_if.err   = err_q[c_PORT_L];
    assign l_if.rdata = rdata_q[c_PORT_L];

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench for dmem_ctrl with a behavioural
//               1-cycle-latency word RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    logic [31:0] mem [0:511];

    int n_total = 0;
    int n_bad   = 0;
    int we_total = 0;
    int we_run   = 0;
    int we_max   = 0;

    dmem_ctrl_if p_bus ();
    dmem_ctrl_if l_bus ();

    dmem_ctrl #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .p_if        (p_bus),
        .l_if        (l_bus),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: write-first not needed; read word appears one edge after address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Track write-enable pulses and the longest run of consecutive highs.
    always @(negedge clk) begin
        if (ram_we) begin
            we_total = we_total + 1;
            we_run   = we_run + 1;
            if (we_run > we_max) we_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p_bus.req = req; p_bus.we = we; p_bus.funct3 = f3; p_bus.addr = addr; p_bus.wdata = wdata;
        end else begin
            l_bus.req = req; l_bus.we = we; l_bus.funct3 = f3; l_bus.addr = addr; l_bus.wdata = wdata;
        end
    endtask

    // One access on one port; lat counts edges from the accepting edge (1)
    // to the edge after which done is visible.
    task automatic access(input logic port, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, we, f3, addr, wdata);
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if ((port ? l_bus.done : p_bus.done) == 1'b1) got = 1;
        end
        if (!got) check_eq("timeout", 32'd0, 32'd1);
        rd = port ? l_bus.rdata : p_bus.rdata;
        er = port ? l_bus.err   : p_bus.err;
        check_eq("other_port_quiet", 32'(port ? p_bus.done : l_bus.done), 32'd0);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we_before;
    logic        order [4];
    int          n_done;
    int          cyc;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_busy",    32'(busy),      32'd0);
        check_eq("rst_we",      32'(ram_we),    32'd0);
        check_eq("rst_addr",    32'(ram_addr),  32'd0);
        check_eq("rst_wdata",   ram_wdata,      32'd0);
        check_eq("rst_p_done",  32'(p_bus.done),32'd0);
        check_eq("rst_l_done",  32'(l_bus.done),32'd0);
        check_eq("rst_p_rdata", p_bus.rdata,    32'd0);
        rst_n = 1'b1;

        // Preload words for the contention test, then reset so arbitration
        // starts from its reset state.
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat);
        access(1'b0, 1'b1, 3'b010, 32'h24, 32'h0BADF00D, rd, er, lat);
        @(negedge clk);
        reset_pulse();

        // Test 4: both ports request together, held; expect P,L,P,L.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h24, 32'd0);
        n_done = 0;
        cyc    = 0;
        while (n_done < 4 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (p_bus.done || l_bus.done) begin
                check_eq("t4_excl", 32'(p_bus.done & l_bus.done), 32'd0);
                order[n_done] = l_bus.done;
                if (l_bus.done) begin
                    check_eq("t4_l_rdata", l_bus.rdata, 32'h0BADF00D);
                    check_eq("t4_p_rdata0", p_bus.rdata, 32'd0);
                end else begin
                    check_eq("t4_p_rdata", p_bus.rdata, 32'hCAFEF00D);
                    check_eq("t4_l_rdata0", l_bus.rdata, 32'd0);
                end
                n_done++;
            end
        end
        if (n_done < 4) check_eq("t4_timeout", 32'(n_done), 32'd4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        for (int i = 0; i < n_done; i++)
            check_eq("t4_order", 32'(order[i]), 32'(i % 2));

        // Test 1: SW then LW
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check_eq("t1_sw_lat", 32'(lat), 32'd2);
        check_eq("t1_sw_err", 32'(er),  32'd0);
        check_eq("t1_ram4",   mem[4],   32'hDEADBEEF);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        check_eq("t1_lw_lat",   32'(lat), 32'd3);
        check_eq("t1_lw_rdata", rd,       32'hDEADBEEF);

        // Test 2: byte/half RMW and extension
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, er, lat);
        access(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, rd, er, lat);
        check_eq("t2_sb_lat", 32'(lat), 32'd4);
        check_eq("t2_sb_ram", mem[4],   32'h1122AA44);
        access(1'b0, 1'b0, 3'b000, 32'h11, 32'd0, rd, er, lat);
        check_eq("t2_lb",  rd, 32'hFFFFFFAA);
        access(1'b0, 1'b0, 3'b100, 32'h11, 32'd0, rd, er, lat);
        check_eq("t2_lbu", rd, 32'h000000AA);
        access(1'b0, 1'b0, 3'b000, 32'h10, 32'd0, rd, er, lat);
        check_eq("t2_lb0", rd, 32'h00000044);
        access(1'b0, 1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat);
        check_eq("t2_lh_hi", rd, 32'h00001122);
        access(1'b0, 1'b1, 3'b001, 32'h12, 32'h12348001, rd, er, lat);
        check_eq("t2_sh_ram", mem[4], 32'h8001AA44);
        access(1'b0, 1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat);
        check_eq("t2_lh_neg", rd, 32'hFFFF8001);
        access(1'b0, 1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat);
        check_eq("t2_lhu", rd, 32'h00008001);

        // Test 3: misaligned and out-of-range
        we_before = we_total;
        access(1'b0, 1'b0, 3'b001, 32'h13, 32'd0, rd, er, lat);
        check_eq("t3_lh_err",   32'(er),  32'd1);
        check_eq("t3_lh_rdata", rd,       32'd0);
        check_eq("t3_lh_lat",   32'(lat), 32'd1);
        access(1'b0, 1'b1, 3'b010, 32'h800, 32'h55555555, rd, er, lat);
        check_eq("t3_sw_err",   32'(er),  32'd1);
        check_eq("t3_sw_rdata", rd,       32'd0);
        check_eq("t3_no_we",    32'(we_total), 32'(we_before));
        check_eq("t3_ram0",     mem[0],   32'h11223344 ^ 32'h11223344 ^ mem[0]);

        // Test 5: reset while an SH sits in WAIT
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, er, lat);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'b001, 32'h12, 32'h0000BEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_we",     32'(ram_we),     32'd0);
        check_eq("t5_busy",   32'(busy),       32'd0);
        check_eq("t5_done",   32'(p_bus.done), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_ram4", mem[4], 32'h11223344);

        // Test 6: illegal encodings on L, then a normal P load
        access(1'b1, 1'b1, 3'b011, 32'h10, 32'h12345678, rd, er, lat);
        check_eq("t6_st011_err", 32'(er), 32'd1);
        check_eq("t6_st011_lat", 32'(lat), 32'd1);
        access(1'b1, 1'b1, 3'b100, 32'h10, 32'h000000FF, rd, er, lat);
        check_eq("t6_sbu_err",   32'(er), 32'd1);
        check_eq("t6_ram4",      mem[4],  32'h11223344);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
        check_eq("t6_lw_err",   32'(er),  32'd0);
        check_eq("t6_lw_lat",   32'(lat), 32'd3);
        check_eq("t6_lw_rdata", rd,       32'h11223344);

        check_eq("we_max_run", 32'(we_max), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule : tb_dmem_ctrl
`default_nettype wire
